// File: rtl/pma_rx_aligner.sv
// 1000BASE-X receive aligner: bit-serial in, /K28.5/-aligned 10-bit groups out; lock/loss via comma counting.
// Group emitted one clock after its last bit; no backpressure, cg_valid strobes once per 10 bits while aligned.
module pma_rx_aligner #(
  parameter int unsigned LOCK_COMMAS = 2,
  parameter int unsigned COMMA_LOSS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_bit,
  output logic [9:0] rx_code_group,
  output logic       cg_valid,
  output logic       comma_det,
  output logic       aligned
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COMMAS);
  localparam logic [3:0] LOSS_N = 4'(COMMA_LOSS);

  state_t     state, state_nxt;
  logic [9:0] sr;
  logic [3:0] ph, ph_nxt;
  logic [3:0] good_cnt, good_nxt, good_inc;
  logic [3:0] miss_cnt, miss_nxt, miss_inc;
  logic       comma_at, boundary, emit;

  // sr[9] is the oldest bit, so a complete comma group has its first 7 bits in sr[9:3]
  assign comma_at = (sr[9:3] == 7'b0011111) || (sr[9:3] == 7'b1100000);
  assign boundary = (state == HUNT) ? comma_at : (ph == 4'd9);
  assign good_inc = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;
  assign miss_inc = (miss_cnt == 4'hF) ? miss_cnt : miss_cnt + 4'd1;
  assign aligned  = (state == LOCKED);

  always_comb begin
    state_nxt = state;
    ph_nxt    = (ph == 4'd9) ? 4'd0 : ph + 4'd1;
    good_nxt  = good_cnt;
    miss_nxt  = miss_cnt;
    emit      = boundary;
    unique case (state)
      HUNT: begin
        if (comma_at) begin
          ph_nxt    = 4'd0;
          good_nxt  = 4'd1;
          miss_nxt  = 4'd0;
          state_nxt = (LOCK_N == 4'd1) ? LOCKED : CHECK;
        end
      end
      CHECK: begin
        if (comma_at && boundary) begin
          good_nxt = good_inc;
          if (good_inc >= LOCK_N) begin
            state_nxt = LOCKED;
            miss_nxt  = 4'd0;
          end
        end else if (comma_at) begin
          // Off-phase comma before lock: trust the newest comma instead
          ph_nxt   = 4'd0;
          good_nxt = 4'd1;
          emit     = 1'b1;
        end
      end
      LOCKED: begin
        if (comma_at && boundary) begin
          miss_nxt = 4'd0;
        end else if (comma_at) begin
          miss_nxt = miss_inc;
          if (miss_inc >= LOSS_N) begin
            state_nxt = HUNT;
            good_nxt  = 4'd0;
            miss_nxt  = 4'd0;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= HUNT;
      sr            <= '0;
      ph            <= '0;
      good_cnt      <= '0;
      miss_cnt      <= '0;
      rx_code_group <= '0;
      cg_valid      <= 1'b0;
      comma_det     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sr       <= {sr[8:0], rx_bit};
      ph       <= ph_nxt;
      good_cnt <= good_nxt;
      miss_cnt <= miss_nxt;
      if (emit) begin
        rx_code_group <= sr;
        cg_valid      <= 1'b1;
        comma_det     <= comma_at;
      end else begin
        cg_valid  <= 1'b0;
        comma_det <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pma_rx_aligner.sv
// Directed bench for pma_rx_aligner: outputs are logged once per bit and compared against hand-derived timelines.
module tb_pma_rx_aligner;

  localparam logic [9:0] K_NEG = 10'h0FA;
  localparam logic [9:0] D16_2 = 10'h245;
  localparam logic [9:0] K_POS = 10'h305;
  localparam logic [9:0] D5_6  = 10'h296;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_bit;
  logic [9:0] rx_code_group;
  logic       cg_valid;
  logic       comma_det;
  logic       aligned;

  int checks = 0;
  int errors = 0;
  int idx = 0;

  logic       lg_vld [0:511];
  logic       lg_cd  [0:511];
  logic       lg_al  [0:511];
  logic [9:0] lg_cg  [0:511];

  pma_rx_aligner dut (
    .clk           (clk),
    .rst           (rst),
    .rx_bit        (rx_bit),
    .rx_code_group (rx_code_group),
    .cg_valid      (cg_valid),
    .comma_det     (comma_det),
    .aligned       (aligned)
  );

  always #5 clk = ~clk;

  // Entry i holds the outputs seen 1 time unit after the edge that sampled bit i
  task automatic send_bit(input logic b);
    rx_bit = b;
    @(posedge clk);
    #1;
    lg_vld[idx] = cg_valid;
    lg_cd[idx]  = comma_det;
    lg_al[idx]  = aligned;
    lg_cg[idx]  = rx_code_group;
    idx++;
  endtask

  task automatic send_group(input logic [9:0] g);
    for (int i = 9; i >= 0; i--) send_bit(g[i]);
  endtask

  task automatic send_fill();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rx_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idx = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rx_bit = 1'($urandom_range(1, 0));
      @(posedge clk);
      #1;
      checks++;
      if ({cg_valid, comma_det, aligned, rx_code_group} !== 13'h0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got vld=%b cd=%b al=%b cg=%h want all 0",
                 i, cg_valid, comma_det, aligned, rx_code_group);
      end
    end
    rst = 1'b1;
  endtask

  // Comma+data pairs after 3 filler bits: group g emitted at obs 13+10g, lock at obs 33
  task automatic test_acquire(input logic [9:0] kg, input logic [9:0] dg, input int npairs, input string tag);
    logic       ev, ecd, eal;
    logic [9:0] ecg;
    do_reset();
    send_fill();
    for (int p = 0; p < npairs; p++) begin
      send_group(kg);
      send_group(dg);
    end
    for (int i = 0; i < idx; i++) begin
      ev  = (i >= 13) && ((i - 13) % 10 == 0);
      ecg = (i < 13) ? 10'h000 : (((((i - 13) / 10) % 2) == 0) ? kg : dg);
      ecd = ev && ((((i - 13) / 10) % 2) == 0);
      eal = (i >= 33);
      checks++;
      if (lg_vld[i] !== ev) begin
        errors++;
        $display("FAIL %s cg_valid obs=%0d got %b want %b", tag, i, lg_vld[i], ev);
      end
      checks++;
      if (lg_cd[i] !== ecd) begin
        errors++;
        $display("FAIL %s comma_det obs=%0d got %b want %b", tag, i, lg_cd[i], ecd);
      end
      checks++;
      if (lg_al[i] !== eal) begin
        errors++;
        $display("FAIL %s aligned obs=%0d got %b want %b", tag, i, lg_al[i], eal);
      end
      checks++;
      if (lg_cg[i] !== ecg) begin
        errors++;
        $display("FAIL %s rx_code_group obs=%0d got %h want %h", tag, i, lg_cg[i], ecg);
      end
    end
  endtask

  // Lock at obs 33, one extra bit after obs 42; off-phase commas at obs 54/74/94/114, relock 134..154
  task automatic test_bit_slip();
    logic ev, ecd, eal;
    do_reset();
    send_fill();
    for (int p = 0; p < 2; p++) begin
      send_group(K_NEG);
      send_group(D16_2);
    end
    send_bit(1'b0);
    for (int p = 0; p < 6; p++) begin
      send_group(K_NEG);
      send_group(D16_2);
    end
    for (int i = 0; i < idx; i++) begin
      if (i <= 113)      ev = (i >= 13) && (i % 10 == 3);
      else if (i <= 133) ev = 1'b0;
      else               ev = (i == 134) || (i == 144) || (i == 154);
      if (i <= 43)       ecd = ev && ((((i - 13) / 10) % 2) == 0);
      else               ecd = (i == 134) || (i == 154);
      eal = ((i >= 33) && (i <= 113)) || (i >= 154);
      checks++;
      if (lg_vld[i] !== ev) begin
        errors++;
        $display("FAIL slip cg_valid obs=%0d got %b want %b", i, lg_vld[i], ev);
      end
      checks++;
      if (lg_cd[i] !== ecd) begin
        errors++;
        $display("FAIL slip comma_det obs=%0d got %b want %b", i, lg_cd[i], ecd);
      end
      checks++;
      if (lg_al[i] !== eal) begin
        errors++;
        $display("FAIL slip aligned obs=%0d got %b want %b", i, lg_al[i], eal);
      end
    end
    checks++;
    if ({lg_cg[134], lg_cg[144], lg_cg[154]} !== {K_NEG, D16_2, K_NEG}) begin
      errors++;
      $display("FAIL slip relock_groups got %h %h %h want %h %h %h",
               lg_cg[134], lg_cg[144], lg_cg[154], K_NEG, D16_2, K_NEG);
    end
  endtask

  // Two extra bits after the first D group: realign at obs 35, lock at obs 55
  task automatic test_check_realign();
    logic ev, ecd, eal;
    do_reset();
    send_fill();
    send_group(K_NEG);
    send_group(D16_2);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int p = 0; p < 2; p++) begin
      send_group(K_NEG);
      send_group(D16_2);
    end
    for (int i = 0; i < idx; i++) begin
      ev  = (i == 13) || (i == 23) || (i == 33) || (i == 35) || (i == 45) || (i == 55);
      ecd = (i == 13) || (i == 35) || (i == 55);
      eal = (i >= 55);
      checks++;
      if (lg_vld[i] !== ev) begin
        errors++;
        $display("FAIL realign cg_valid obs=%0d got %b want %b", i, lg_vld[i], ev);
      end
      checks++;
      if (lg_cd[i] !== ecd) begin
        errors++;
        $display("FAIL realign comma_det obs=%0d got %b want %b", i, lg_cd[i], ecd);
      end
      checks++;
      if (lg_al[i] !== eal) begin
        errors++;
        $display("FAIL realign aligned obs=%0d got %b want %b", i, lg_al[i], eal);
      end
    end
    checks++;
    if ({lg_cg[23], lg_cg[33], lg_cg[35], lg_cg[45], lg_cg[55]} !==
        {D16_2, 10'h23E, K_NEG, D16_2, K_NEG}) begin
      errors++;
      $display("FAIL realign groups got %h %h %h %h %h want 245 23e 0fa 245 0fa",
               lg_cg[23], lg_cg[33], lg_cg[35], lg_cg[45], lg_cg[55]);
    end
  endtask

  task automatic test_reset_locked();
    do_reset();
    send_fill();
    send_group(K_NEG);
    send_group(D16_2);
    send_group(K_NEG);
    send_bit(1'b1);
    checks++;
    if ({aligned, cg_valid, rx_code_group} !== {1'b1, 1'b1, K_NEG}) begin
      errors++;
      $display("FAIL rst_locked pre got al=%b vld=%b cg=%h want al=1 vld=1 cg=%h",
               aligned, cg_valid, rx_code_group, K_NEG);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({aligned, cg_valid, comma_det, rx_code_group} !== 13'h0) begin
      errors++;
      $display("FAIL rst_locked async got al=%b vld=%b cd=%b cg=%h want all 0",
               aligned, cg_valid, comma_det, rx_code_group);
    end
    test_acquire(K_NEG, D16_2, 3, "rst_relock");
  endtask

  initial begin
    rst = 1'b0;
    rx_bit = 1'b0;
    test_reset();
    test_acquire(K_NEG, D16_2, 10, "idle");
    test_acquire(K_POS, D5_6, 5, "rd_plus");
    test_bit_slip();
    test_check_realign();
    test_reset_locked();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
